jtframe_multi_wait: RTL and testbench

Generalised clock-enable gating and cycle-recovery block for up to `CHN` CPUs. Each channel suppresses its CPU's clock enable while its ROM data is not ready from SDRAM or a shared device is busy. It counts the enables it drops and gives them back later, at a rate-limited pace, while that CPU's bus is idle. It sits between the frame clock-enable generator and the CPU cores of multi-CPU games.

---
 rtl/jtframe_multi_wait.sv | 89 ++++++++
 tb/tb_jtframe_multi_wait.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_multi_wait.sv
// Per-channel clock-enable gating with rate-limited recovery of dropped enables.
// Recovery is built only when JTFRAME_WAIT_RECOVER_EN is defined; otherwise plain gating.
module jtframe_multi_wait #(
  parameter int CHN    = 2,
  parameter int MISSW  = 4,
  parameter int RECGAP = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CHN-1:0] start,
  input  logic [CHN-1:0] cen_in,
  output logic [CHN-1:0] cen_out,
  output logic [CHN-1:0] gate,
  input  logic [CHN-1:0] rom_cs,
  input  logic [CHN-1:0] rom_ok,
  input  logic [CHN-1:0] dev_busy,
  input  logic [CHN-1:0] bus_idle,
  output logic [CHN-1:0] miss_ovf
);

  logic [CHN-1:0] last_cs;
  logic [CHN-1:0] locked;
  logic [CHN-1:0] rom_rise;
  logic [CHN-1:0] rom_bad;
  logic [CHN-1:0] rec;

  always_comb begin
    rom_rise = rom_cs & ~last_cs;
    rom_bad  = (rom_cs & ~rom_ok) | rom_rise;
    gate     = start & ~(rom_bad | dev_busy | locked);
    cen_out  = (cen_in & gate) | rec;
  end

  // last_cs resets high so a request already active out of reset is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_cs <= '1;
      locked  <= '0;
    end else begin
      last_cs <= rom_cs;
      locked  <= rom_bad | dev_busy;
    end
  end

`ifdef JTFRAME_WAIT_RECOVER_EN
  localparam int GW = (RECGAP > 0) ? $clog2(RECGAP + 1) : 1;

  genvar i;
  generate
    for (i = 0; i < CHN; i++) begin : g_rec
      logic [MISSW-1:0] miss;
      logic [GW-1:0]    gapcnt;
      logic             ovf;
      logic             drop;

      assign drop     = cen_in[i] & ~gate[i];
      assign rec[i]   = start[i] & (miss != '0) & ~cen_in[i] & bus_idle[i] & (gapcnt == '0);
      assign miss_ovf[i] = ovf;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          miss   <= '0;
          gapcnt <= '0;
          ovf    <= 1'b0;
        end else if (!start[i]) begin
          miss   <= '0;
          gapcnt <= '0;
          ovf    <= 1'b0;
        end else begin
          if (drop) begin
            if (miss == '1) ovf  <= 1'b1;
            else            miss <= miss + 1'b1;
          end else if (rec[i]) begin
            miss <= miss - 1'b1;
          end
          if (rec[i])              gapcnt <= GW'(RECGAP);
          else if (gapcnt != '0)   gapcnt <= gapcnt - 1'b1;
        end
      end
    end
  endgenerate
`else
  logic unused_bus_idle;
  assign unused_bus_idle = &{1'b0, bus_idle};
  assign rec      = '0;
  assign miss_ovf = '0;
`endif

endmodule

// File: tb/tb_jtframe_multi_wait.sv
// Bench for jtframe_multi_wait: two instances (RECGAP 0 and 3) share stimulus and are
// checked every cycle against a timestamp/history model, plus hand-computed scenario counts.
module tb_jtframe_multi_wait;
  localparam int MISSW = 4;
  localparam int MAXM  = (1 << MISSW) - 1;
`ifdef JTFRAME_WAIT_RECOVER_EN
  localparam bit REC_EN = 1'b1;
`else
  localparam bit REC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start, cen_in, rom_cs, rom_ok, dev_busy, bus_idle;
  logic [1:0] cen_out0, gate0, ovf0;
  logic [1:0] cen_out1, gate1, ovf1;

  always #5 clk = ~clk;

  jtframe_multi_wait #(.CHN(2), .MISSW(MISSW), .RECGAP(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .cen_in(cen_in), .cen_out(cen_out0),
    .gate(gate0), .rom_cs(rom_cs), .rom_ok(rom_ok), .dev_busy(dev_busy),
    .bus_idle(bus_idle), .miss_ovf(ovf0)
  );

  jtframe_multi_wait #(.CHN(2), .MISSW(MISSW), .RECGAP(3)) u1 (
    .clk(clk), .rst(rst), .start(start), .cen_in(cen_in), .cen_out(cen_out1),
    .gate(gate1), .rom_cs(rom_cs), .rom_ok(rom_ok), .dev_busy(dev_busy),
    .bus_idle(bus_idle), .miss_ovf(ovf1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: lock is "a stall was seen last cycle", gap spacing is a
  // timestamp of the last recovery, pending misses are a plain integer.
  int gaps [2] = '{0, 3};
  int m_miss [2][2];
  int m_last [2][2];
  bit m_pcs  [2][2];
  bit m_pst  [2][2];
  bit m_ovf  [2][2];
  int mcyc = 0;

  always @(negedge clk) begin : model
    bit rise, bad, st, g, r, co;
    int ag, aco, aov;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        if (rst) begin
          m_miss[d][c] = 0;
          m_last[d][c] = -100;
          m_pcs[d][c]  = 1'b1;
          m_pst[d][c]  = 1'b0;
          m_ovf[d][c]  = 1'b0;
        end
        rise = rom_cs[c] && !m_pcs[d][c];
        bad  = (rom_cs[c] && !rom_ok[c]) || rise;
        st   = bad || dev_busy[c];
        g    = start[c] && !st && !m_pst[d][c];
        r    = REC_EN && start[c] && (m_miss[d][c] > 0) && !cen_in[c] && bus_idle[c]
               && (mcyc - m_last[d][c] > gaps[d]);
        co   = (cen_in[c] && g) || r;
        ag   = (d == 0) ? int'(gate0[c])    : int'(gate1[c]);
        aco  = (d == 0) ? int'(cen_out0[c]) : int'(cen_out1[c]);
        aov  = (d == 0) ? int'(ovf0[c])     : int'(ovf1[c]);
        chk($sformatf("gate u%0d ch%0d", d, c), ag, int'(g));
        chk($sformatf("cen_out u%0d ch%0d", d, c), aco, int'(co));
        chk($sformatf("miss_ovf u%0d ch%0d", d, c), aov, int'(m_ovf[d][c]));
        if (!rst) begin
          m_pcs[d][c] = rom_cs[c];
          m_pst[d][c] = st;
          if (!start[c]) begin
            m_miss[d][c] = 0;
            m_last[d][c] = -100;
            m_ovf[d][c]  = 1'b0;
          end else if (cen_in[c] && !g) begin
            if (m_miss[d][c] == MAXM) m_ovf[d][c] = REC_EN;
            else                      m_miss[d][c]++;
          end else if (r) begin
            m_miss[d][c]--;
          end
          if (r) m_last[d][c] = mcyc;
        end
      end
    end
    mcyc++;
  end

  int tcyc = 0;
  int n_glow, n_drop, n_rec0, n_rec1, n_close, n_rec_busy, n_out0, n_out1, n_in1, last_r1;

  task automatic clr();
    n_glow = 0; n_drop = 0; n_rec0 = 0; n_rec1 = 0; n_close = 0;
    n_rec_busy = 0; n_out0 = 0; n_out1 = 0; n_in1 = 0; last_r1 = -1;
  endtask

  task automatic tick();
    @(negedge clk);
    if (!gate0[0]) n_glow++;
    if (cen_in[0] && !gate0[0]) n_drop++;
    if (cen_out0[0] && !cen_in[0]) begin
      n_rec0++;
      if (!bus_idle[0]) n_rec_busy++;
    end
    if (cen_out1[0] && !cen_in[0]) begin
      n_rec1++;
      if (last_r1 >= 0 && tcyc - last_r1 < 4) n_close++;
      last_r1 = tcyc;
    end
    if (cen_out0[0]) n_out0++;
    if (cen_out0[1]) n_out1++;
    if (cen_in[1])   n_in1++;
    tcyc++;
    @(posedge clk);
    #1;
  endtask

  int rec_exp;
  int busy_left [2];

  initial begin
    rec_exp  = REC_EN ? 6 : 0;
    start    = 2'b11;
    cen_in   = 2'b00;
    rom_cs   = 2'b11;
    rom_ok   = 2'b11;
    dev_busy = 2'b00;
    bus_idle = 2'b11;
    clr();

    // reset with request already active: no edge, gates open
    @(negedge clk);
    chk("reset gate u0", int'(gate0), 3);
    chk("reset ovf u0", int'(ovf0), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    clr();
    for (int i = 0; i < 40; i++) begin
      cen_in = (i % 4 == 0) ? 2'b11 : 2'b00;
      tick();
    end
    chk("no-stall ch0 pulses", n_out0, 10);
    chk("no-stall ch1 pulses", n_out1, 10);
    chk("no-stall recoveries", n_rec0, 0);

    // ROM stall on channel 0: rom_ok arrives 11 cycles after the request edge
    rom_cs[0] = 1'b0; rom_ok[0] = 1'b0; bus_idle[0] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      cen_in = (j % 2 == 0) ? 2'b11 : 2'b00;
      tick();
    end
    clr();
    for (int j = 0; j < 20; j++) begin
      rom_cs[0] = 1'b1;
      rom_ok[0] = (j >= 11);
      cen_in    = (j % 2 == 0) ? 2'b11 : 2'b00;
      tick();
    end
    chk("stall gate-low cycles", n_glow, 12);
    chk("stall dropped pulses", n_drop, 6);
    chk("ch1 unaffected", n_out1, n_in1);
    chk("ch1 pulse count", n_in1, 10);

    // recovery with a bus-busy pause in the middle
    clr();
    for (int j = 0; j < 60; j++) begin
      bus_idle[0] = !(j >= 4 && j < 12);
      cen_in      = (j % 2 == 0) ? 2'b11 : 2'b00;
      tick();
    end
    chk("recovered RECGAP=0", n_rec0, rec_exp);
    chk("recovered RECGAP=3", n_rec1, rec_exp);
    chk("RECGAP=3 spacing violations", n_close, 0);
    chk("recovery while bus busy", n_rec_busy, 0);

    // saturation via dev_busy for 40 pulses
    bus_idle[0] = 1'b0;
    dev_busy[0] = 1'b1;
    for (int j = 0; j < 80; j++) begin
      cen_in = (j % 2 == 0) ? 2'b11 : 2'b00;
      tick();
    end
    dev_busy[0] = 1'b0;
    cen_in = 2'b00;
    tick();
    tick();
    chk("ovf set u0", int'(ovf0[0]), REC_EN ? 1 : 0);
    chk("ovf set u1", int'(ovf1[0]), REC_EN ? 1 : 0);
    chk("ovf ch1 clear", int'(ovf0[1]), 0);
    start[0] = 1'b0;
    tick();
    chk("ovf cleared by start", int'(ovf0[0]), 0);
    start[0] = 1'b1;
    bus_idle = 2'b11;
    clr();
    for (int j = 0; j < 20; j++) begin
      cen_in = (j % 2 == 0) ? 2'b11 : 2'b00;
      tick();
    end
    chk("no recovery after start clear", n_rec0, 0);

    // randomized traffic, with occasional async resets and long busy bursts
    busy_left = '{0, 0};
    for (int k = 0; k < 3000; k++) begin
      if (!rst && $urandom_range(0, 399) == 0) rst = 1'b1;
      else if (rst) rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
        start[c]    = ($urandom_range(0, 99) != 0);
        cen_in[c]   = ($urandom_range(0, 2) == 0);
        rom_cs[c]   = ($urandom_range(0, 7) != 0);
        rom_ok[c]   = ($urandom_range(0, 3) != 0);
        bus_idle[c] = ($urandom_range(0, 9) < 7);
        if (busy_left[c] > 0) busy_left[c]--;
        else if ($urandom_range(0, 39) == 0) busy_left[c] = int'($urandom_range(1, 50));
        dev_busy[c] = (busy_left[c] > 0);
      end
      tick();
    end
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
